// File: rtl/hsid_x_mse_scan.sv
// Scan sequencer between the HSpecID-X register block and the MSE datapath:
// issues one band request per (pixel, band) and tracks min/max MSE results.
module hsid_x_mse_scan #(
    parameter  int WORD_WIDTH            = 32,
    parameter  int HSI_BANDS             = 128,
    parameter  int HSI_LIBRARY_SIZE      = 256,
    localparam int HSI_BANDS_ADDR        = $clog2(HSI_BANDS),
    localparam int HSI_LIBRARY_SIZE_ADDR = $clog2(HSI_LIBRARY_SIZE)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             clear,
    input  logic [HSI_LIBRARY_SIZE_ADDR-1:0] library_size,
    input  logic [HSI_BANDS_ADDR-1:0]        pixel_bands,
    output logic                             idle,
    output logic                             ready,
    output logic                             done,
    output logic                             error,
    output logic                             band_req_valid,
    input  logic                             band_req_ready,
    output logic [HSI_LIBRARY_SIZE_ADDR-1:0] band_req_ref,
    output logic [HSI_BANDS_ADDR-1:0]        band_req_band,
    output logic                             band_req_last,
    input  logic                             mse_valid,
    input  logic [HSI_LIBRARY_SIZE_ADDR-1:0] mse_ref,
    input  logic [WORD_WIDTH-1:0]            mse_value,
    input  logic                             mse_overflow,
    output logic [HSI_LIBRARY_SIZE_ADDR-1:0] mse_min_ref,
    output logic [WORD_WIDTH-1:0]            mse_min_value,
    output logic [HSI_LIBRARY_SIZE_ADDR-1:0] mse_max_ref,
    output logic [WORD_WIDTH-1:0]            mse_max_value
);

    localparam int LA = HSI_LIBRARY_SIZE_ADDR;
    localparam int BA = HSI_BANDS_ADDR;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_ERROR} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [LA-1:0]      r_size;
    logic [BA-1:0]      r_bands;
    logic [LA:0]        r_cnt;
    logic [LA:0]        w_cnt_next;
    logic               r_idle, r_ready, r_done, r_error;
    logic               r_valid, r_last;
    logic [LA-1:0]      r_ref;
    logic [BA-1:0]      r_band;
    logic [LA-1:0]      r_min_ref, r_max_ref;
    logic [WORD_WIDTH-1:0] r_min_val, r_max_val;
    logic               w_accept, w_bad, w_good, w_all_in, w_hs, w_issue_end;
    logic               w_cfg_ok, w_launch;

    always_comb begin
        w_accept    = mse_valid && (r_state == S_ISSUE || r_state == S_WAIT);
        w_bad       = w_accept && (mse_overflow || mse_ref >= r_size);
        w_good      = w_accept && !w_bad;
        w_cnt_next  = r_cnt + {{LA{1'b0}}, w_good};
        w_all_in    = w_cnt_next >= {1'b0, r_size};
        w_hs        = r_valid && band_req_ready;
        w_issue_end = w_hs && r_last && (r_ref == r_size - LA'(1));
        w_cfg_ok    = (library_size != '0) && (pixel_bands != '0);
        w_launch    = !clear && start && (r_state == S_IDLE || r_state == S_DONE) && w_cfg_ok;

        w_state_next = r_state;
        if (clear) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: if (start) w_state_next = w_cfg_ok ? S_ISSUE : S_ERROR;
                // Results that all arrive before issuing finishes skip WAIT entirely
                S_ISSUE: begin
                    if (w_bad)            w_state_next = S_ERROR;
                    else if (w_issue_end) w_state_next = w_all_in ? S_DONE : S_WAIT;
                end
                S_WAIT: begin
                    if (w_bad)         w_state_next = S_ERROR;
                    else if (w_all_in) w_state_next = S_DONE;
                end
                default: w_state_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_idle    <= 1'b1;
            r_ready   <= 1'b1;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_valid   <= 1'b0;
            r_ref     <= '0;
            r_band    <= '0;
            r_last    <= 1'b0;
            r_size    <= '0;
            r_bands   <= '0;
            r_cnt     <= '0;
            r_min_val <= '1;
            r_min_ref <= '0;
            r_max_val <= '0;
            r_max_ref <= '0;
        end else begin
            r_state <= w_state_next;
            r_idle  <= (w_state_next == S_IDLE);
            r_ready <= (w_state_next == S_IDLE) || (w_state_next == S_DONE);
            r_done  <= (w_state_next == S_DONE);
            r_error <= (w_state_next == S_ERROR);

            if (clear || w_launch) begin
                r_valid   <= w_launch;
                r_ref     <= '0;
                r_band    <= '0;
                r_last    <= w_launch && (pixel_bands == BA'(1));
                r_cnt     <= '0;
                r_min_val <= '1;
                r_min_ref <= '0;
                r_max_val <= '0;
                r_max_ref <= '0;
                if (w_launch) begin
                    r_size  <= library_size;
                    r_bands <= pixel_bands;
                end
            end else begin
                if (w_hs) begin
                    if (r_last) begin
                        r_band <= '0;
                        r_ref  <= r_ref + LA'(1);
                        r_last <= (r_bands == BA'(1));
                    end else begin
                        r_band <= r_band + BA'(1);
                        r_last <= (r_band + BA'(1)) == (r_bands - BA'(1));
                    end
                end
                if (w_state_next != S_ISSUE) r_valid <= 1'b0;
                if (w_good) begin
                    r_cnt <= w_cnt_next;
                    if (r_cnt == '0 || mse_value < r_min_val) begin
                        r_min_val <= mse_value;
                        r_min_ref <= mse_ref;
                    end
                    if (r_cnt == '0 || mse_value > r_max_val) begin
                        r_max_val <= mse_value;
                        r_max_ref <= mse_ref;
                    end
                end
            end
        end
    end

    assign idle           = r_idle;
    assign ready          = r_ready;
    assign done           = r_done;
    assign error          = r_error;
    assign band_req_valid = r_valid;
    assign band_req_ref   = r_ref;
    assign band_req_band  = r_band;
    assign band_req_last  = r_last;
    assign mse_min_ref    = r_min_ref;
    assign mse_min_value  = r_min_val;
    assign mse_max_ref    = r_max_ref;
    assign mse_max_value  = r_max_val;

endmodule

// File: doc/hsid_x_mse_scan.md
Name: hsid_x_mse_scan

Overview:
Scan sequencer directly downstream of the HSpecID-X control register block. It consumes the start/clear pulses and the library_size/pixel_bands configuration. It then walks the library by issuing one band request per (library pixel, band) pair to the MSE datapath, and collects one MSE result per library pixel while tracking the minimum and maximum. It returns idle/ready/done/error and the min/max references and values to the register block for software readback.

Parameters:
WORD_WIDTH, 32, width of MSE values
HSI_BANDS, 128, max bands per pixel; HSI_BANDS_ADDR = $clog2(HSI_BANDS) (localparam)
HSI_LIBRARY_SIZE, 256, max library pixels; HSI_LIBRARY_SIZE_ADDR = $clog2(HSI_LIBRARY_SIZE) (localparam)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle start pulse from register block
clear  in  1  one-cycle clear/abort pulse from register block
library_size  in  HSI_LIBRARY_SIZE_ADDR  number of library pixels to scan
pixel_bands  in  HSI_BANDS_ADDR  bands per pixel
idle  out  1  high only in IDLE
ready  out  1  start will be accepted (IDLE or DONE)
done  out  1  scan completed without error
error  out  1  scan aborted on error
band_req_valid  out  1  band request valid
band_req_ready  in  1  datapath accepts request
band_req_ref  out  HSI_LIBRARY_SIZE_ADDR  library pixel index of request
band_req_band  out  HSI_BANDS_ADDR  band index of request
band_req_last  out  1  last band of current pixel
mse_valid  in  1  MSE result valid (always accepted, no backpressure)
mse_ref  in  HSI_LIBRARY_SIZE_ADDR  library pixel index of result
mse_value  in  WORD_WIDTH  MSE result
mse_overflow  in  1  datapath accumulator overflow for this result
mse_min_ref  out  HSI_LIBRARY_SIZE_ADDR  ref of minimum MSE
mse_min_value  out  WORD_WIDTH  minimum MSE
mse_max_ref  out  HSI_LIBRARY_SIZE_ADDR  ref of maximum MSE
mse_max_value  out  WORD_WIDTH  maximum MSE

Behaviour:
- Reset (async, rst=1): state IDLE; idle=1, ready=1, done=0, error=0, band_req_valid=0, band_req_ref=0, band_req_band=0, band_req_last=0; mse_min_value=all ones, mse_min_ref=0, mse_max_value=0, mse_max_ref=0; counters cleared.
- States: IDLE, ISSUE, WAIT, DONE, ERROR. All outputs are registered or decoded from state only.
- clear takes priority over start in every state. It moves to IDLE next cycle, drops band_req_valid, and restores min/max to reset values.
- IDLE/DONE + start:
  - library_size==0 or pixel_bands==0 -> ERROR.
  - Otherwise latch config, zero counters, reset min/max, enter ISSUE next cycle.
  - start in ISSUE/WAIT/ERROR is ignored.
- ISSUE: band_req_valid=1. Payload is held stable until band_req_ready.
  - On handshake, band increments.
  - At band==latched_bands-1: band_req_last=1; band wraps to 0 and ref increments.
  - After the handshake with ref==latched_size-1 and band_req_last=1 -> WAIT, band_req_valid=0.
- Results are accepted in ISSUE and WAIT; in other states they are discarded.
  - Per accepted result, increment result count.
  - If mse_value < min (strict), update min_value/min_ref.
  - If mse_value > max (strict), update max_value/max_ref.
  - Ties keep the earlier ref. The first result updates both min and max.
  - min/max outputs update the cycle after mse_valid.
- Error conditions in ISSUE/WAIT:
  - mse_overflow=1 or mse_ref >= latched_size -> ERROR next cycle.
  - min/max are frozen at their last values (the offending result is not merged).
- Completion: when the accepted result count reaches latched_size -> DONE the cycle after the last result (done=1, ready=1, idle=0). This also applies if the last result arrives while still in ISSUE; in that case the transition to DONE happens once ISSUE completes.
- DONE/ERROR hold until clear (both states) or start (DONE only). Outputs hold their final values.
- Counters are sized so that library_size max (2^HSI_LIBRARY_SIZE_ADDR-1) does not wrap.

Test Plan:
- Nominal: library_size=4, pixel_bands=3, band_req_ready=1, results refs 0..3 with values 50,20,90,20 → exactly 12 requests (band_req_last on 3rd, 6th, 9th, 12th). Final state: done=1, min=20/ref1, max=90/ref2.
- Backpressure: band_req_ready toggles 1010… with library_size=2, pixel_bands=2 → payload stable while stalled, 4 handshakes in order (0,0),(0,1),(1,0),(1,1).
- Bad config: start with pixel_bands=0 → error=1 next cycle, no band_req_valid. A following clear → idle=1, error=0.
- Overflow: library_size=3, second result has mse_overflow=1 → error=1; min/max reflect only the first result.
- Abort: clear mid-ISSUE → band_req_valid=0 and idle=1 next cycle, min=all ones; a later start rescans from ref 0.
- Async reset asserted in WAIT → all outputs at reset values immediately, without waiting for a clock edge.
